alu_div_sequencer: RTL and testbench

Multicycle unsigned divider controller that sequences a dedicated ALU instance through restoring division, one quotient bit per two clocks. It supplies the DIV operation (ALUControl 8) that the combinational ALU does not implement. It sits beside the execute stage and exposes a start/busy/done handshake to the stall logic. It drives only the ALU operands and control code, and consumes only ALUResult.

---
 rtl/alu_div_sequencer.sv | 133 +++++++++++++
 tb/tb_alu_div_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_div_sequencer.sv
// Multicycle restoring unsigned divider that borrows an external ALU for
// compare (SLT) and subtract, producing one quotient bit every two clocks.
module alu_div_sequencer #(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned BIT_SEL   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BIT_WIDTH-1:0] dividend,
  input  logic [BIT_WIDTH-1:0] divisor,
  output logic [BIT_WIDTH-1:0] alu_src_a,
  output logic [BIT_WIDTH-1:0] alu_src_b,
  output logic [BIT_SEL:0]     alu_control,
  input  logic [BIT_WIDTH-1:0] alu_result,
  output logic [BIT_WIDTH-1:0] quotient,
  output logic [BIT_WIDTH-1:0] remainder,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero
);

  localparam int unsigned CntW = $clog2(BIT_WIDTH);

  localparam logic [BIT_SEL:0] AluAdd = (BIT_SEL+1)'(0);
  localparam logic [BIT_SEL:0] AluSlt = (BIT_SEL+1)'(4);
  localparam logic [BIT_SEL:0] AluSub = (BIT_SEL+1)'(7);

  typedef enum logic [1:0] {StIdle, StCmp, StSub, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0] r_q, r_d;
  logic [BIT_WIDTH-1:0] q_q, q_d;
  logic [BIT_WIDTH-1:0] d_q, d_d;
  logic                 lt_q, lt_d;
  logic [BIT_WIDTH-1:0] quot_q, quot_d;
  logic [BIT_WIDTH-1:0] rem_q, rem_d;
  logic                 dz_q, dz_d;
  logic [BIT_WIDTH-1:0] rs;

  // Partial remainder stays below 2^k after k bits, so the shift never overflows.
  assign rs = {r_q[BIT_WIDTH-2:0], q_q[BIT_WIDTH-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      lt_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      lt_q    <= lt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    lt_d        = lt_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dz_d        = dz_q;
    alu_src_a   = '0;
    alu_src_b   = '0;
    alu_control = AluAdd;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dz_d    = 1'b1;
            state_d = StDone;
          end else begin
            d_d     = divisor;
            q_d     = dividend;
            r_d     = '0;
            cnt_d   = CntW'(BIT_WIDTH - 1);
            dz_d    = 1'b0;
            state_d = StCmp;
          end
        end
      end
      StCmp: begin
        alu_src_a   = rs;
        alu_src_b   = d_q;
        alu_control = AluSlt;
        lt_d        = alu_result[0];
        state_d     = StSub;
      end
      StSub: begin
        alu_src_a   = rs;
        alu_src_b   = d_q;
        alu_control = AluSub;
        r_d         = lt_q ? rs : alu_result;
        q_d         = {q_q[BIT_WIDTH-2:0], ~lt_q};
        if (cnt_q == '0) begin
          quot_d  = q_d;
          rem_d   = r_d;
          state_d = StDone;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          state_d = StCmp;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Directed bench for alu_div_sequencer with a behavioural ALU closing the loop.
module tb_alu_div_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] alu_src_a;
  logic [31:0] alu_src_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int n_checks;
  int n_fail;

  alu_div_sequencer #(.BIT_WIDTH(32), .BIT_SEL(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unsigned set-less-than so full-range operands compare correctly.
  always_comb begin
    alu_result = 32'h0;
    case (alu_control)
      4'd0: alu_result = alu_src_a + alu_src_b;
      4'd4: alu_result = {31'h0, alu_src_a < alu_src_b};
      4'd7: alu_result = alu_src_a - alu_src_b;
      default: alu_result = 32'h0;
    endcase
  end

  // Starts a divide at the next edge and returns the negedge index where done
  // first appears (0 on timeout) plus a count of wrong ALU codes seen.
  // With inject set, extra starts are pulsed in CMP, SUB and DONE.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit inject,
                         output int lat, output int ctl_err);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat     = 0;
    ctl_err = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
      if (b != 0 && alu_control !== ((n % 2 == 1) ? 4'd4 : 4'd7)) ctl_err++;
      if (inject && (n == 1 || n == 2)) begin
        dividend = 32'd1000 + n;
        divisor  = 32'd3;
        start    = 1'b1;
      end
    end
    if (inject && lat != 0) begin
      dividend = 32'd55;
      divisor  = 32'd0;
      start    = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #2;
    n_checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 67'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b dz=%b q=%h r=%h, want all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    n_checks++;
    if ({alu_src_a, alu_src_b, alu_control} !== 68'h0) begin
      n_fail++;
      $display("FAIL reset_alu: got a=%h b=%h ctl=%0d, want 0/0/0",
               alu_src_a, alu_src_b, alu_control);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, ce;
    run_div(32'd100, 32'd7, 1'b0, lat, ce);
    n_checks++;
    if (lat != 65) begin
      n_fail++; $display("FAIL basic_latency: got %0d, want 65", lat);
    end
    n_checks++;
    if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got q=%0d r=%0d dz=%b, want 14 2 0",
               quotient, remainder, div_by_zero);
    end
    n_checks++;
    if (ce != 0) begin
      n_fail++; $display("FAIL basic_alu_sequence: got %0d bad codes, want 0", ce);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy_in_done: got %b, want 1", busy);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd14) begin
      n_fail++;
      $display("FAIL basic_idle_after: got busy=%b done=%b q=%0d, want 0 0 14",
               busy, done, quotient);
    end
  endtask

  task automatic test_full_range;
    int lat, ce;
    run_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, lat, ce);
    n_checks++;
    if (lat != 65 || quotient !== 32'h1 || remainder !== 32'h7FFF_FFFE) begin
      n_fail++;
      $display("FAIL full_range_max: got lat=%0d q=%h r=%h, want 65 00000001 7ffffffe",
               lat, quotient, remainder);
    end
    run_div(32'h1234_5678, 32'h1, 1'b0, lat, ce);
    n_checks++;
    if (lat != 65 || quotient !== 32'h1234_5678 || remainder !== 32'h0) begin
      n_fail++;
      $display("FAIL full_range_div1: got lat=%0d q=%h r=%h, want 65 12345678 00000000",
               lat, quotient, remainder);
    end
  endtask

  task automatic test_small_over_large;
    int lat, ce;
    run_div(32'd5, 32'd9, 1'b0, lat, ce);
    n_checks++;
    if (lat != 65 || quotient !== 32'd0 || remainder !== 32'd5) begin
      n_fail++;
      $display("FAIL small_over_large: got lat=%0d q=%0d r=%0d, want 65 0 5",
               lat, quotient, remainder);
    end
  endtask

  task automatic test_div_by_zero;
    int lat, ce;
    run_div(32'hDEAD_BEEF, 32'h0, 1'b0, lat, ce);
    n_checks++;
    if (lat != 1) begin
      n_fail++; $display("FAIL dbz_latency: got %0d, want 1", lat);
    end
    n_checks++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== 32'hDEAD_BEEF || div_by_zero !== 1'b1
        || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL dbz_result: got q=%h r=%h dz=%b busy=%b, want ffffffff deadbeef 1 1",
               quotient, remainder, div_by_zero, busy);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dbz_hold: got busy=%b dz=%b, want 0 1", busy, div_by_zero);
    end
    run_div(32'd20, 32'd6, 1'b0, lat, ce);
    n_checks++;
    if (div_by_zero !== 1'b0 || quotient !== 32'd3 || remainder !== 32'd2) begin
      n_fail++;
      $display("FAIL dbz_cleared: got dz=%b q=%0d r=%0d, want 0 3 2",
               div_by_zero, quotient, remainder);
    end
  endtask

  task automatic test_ignored_starts;
    int lat, ce;
    int busy_seen;
    run_div(32'd100, 32'd7, 1'b1, lat, ce);
    n_checks++;
    if (lat != 65 || quotient !== 32'd14 || remainder !== 32'd2) begin
      n_fail++;
      $display("FAIL ignored_starts_result: got lat=%0d q=%0d r=%0d, want 65 14 2",
               lat, quotient, remainder);
    end
    busy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy !== 1'b0) busy_seen++;
    end
    n_checks++;
    if (busy_seen != 0 || div_by_zero !== 1'b0 || quotient !== 32'd14) begin
      n_fail++;
      $display("FAIL ignored_starts_no_replay: got busy_cycles=%0d dz=%b q=%0d, want 0 0 14",
               busy_seen, div_by_zero, quotient);
    end
  endtask

  task automatic test_reset_mid_op;
    int lat, ce;
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 21; n++) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || alu_control !== 4'd4) begin
      n_fail++;
      $display("FAIL midop_precondition: got busy=%b ctl=%0d, want 1 4", busy, alu_control);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 67'h0
        || {alu_src_a, alu_src_b, alu_control} !== 68'h0) begin
      n_fail++;
      $display("FAIL midop_async_reset: got busy=%b done=%b dz=%b q=%h r=%h a=%h b=%h ctl=%0d, want all 0",
               busy, done, div_by_zero, quotient, remainder, alu_src_a, alu_src_b, alu_control);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_div(32'd1000, 32'd33, 1'b0, lat, ce);
    n_checks++;
    if (lat != 65 || quotient !== 32'd30 || remainder !== 32'd10 || ce != 0) begin
      n_fail++;
      $display("FAIL midop_fresh_divide: got lat=%0d q=%0d r=%0d ctl_err=%0d, want 65 30 10 0",
               lat, quotient, remainder, ce);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_full_range();
    test_small_over_large();
    test_div_by_zero();
    test_ignored_starts();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
